// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the bus CPU control path.
// Holds the opcode constants, the ALU control encodings, the IR field
// positions, the instruction-class decode and the sequencer state enumeration.
package cpu_pkg;

  // IR field bit positions
  localparam int unsigned OP_MSB = 31;
  localparam int unsigned OP_LSB = 27;
  localparam int unsigned RA_MSB = 26;
  localparam int unsigned RA_LSB = 23;
  localparam int unsigned RB_MSB = 22;
  localparam int unsigned RB_LSB = 19;
  localparam int unsigned RC_MSB = 18;
  localparam int unsigned RC_LSB = 15;

  // Opcodes
  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_SHR  = 5'b00100;
  localparam logic [4:0] OP_SHL  = 5'b00101;
  localparam logic [4:0] OP_ROR  = 5'b00110;
  localparam logic [4:0] OP_ROL  = 5'b00111;
  localparam logic [4:0] OP_MUL  = 5'b01000;
  localparam logic [4:0] OP_DIV  = 5'b01001;
  localparam logic [4:0] OP_NEG  = 5'b01010;
  localparam logic [4:0] OP_NOT  = 5'b01011;
  localparam logic [4:0] OP_HALT = 5'b11011;

  // ALU control encodings (equal to op[3:0] for every ALU opcode)
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_SHR = 4'd4,
    ALU_SHL = 4'd5,
    ALU_ROR = 4'd6,
    ALU_ROL = 4'd7,
    ALU_MUL = 4'd8,
    ALU_DIV = 4'd9,
    ALU_NEG = 4'd10,
    ALU_NOT = 4'd11
  } alu_ctl_e;

  typedef enum logic [2:0] {
    CL_RRR,
    CL_MD,
    CL_UN,
    CL_HALT,
    CL_NOP
  } iclass_e;

  typedef enum logic [3:0] {
    S_RESET,
    S_T0,
    S_T1,
    S_WAIT,
    S_T2,
    S_T3,
    S_T4,
    S_T5,
    S_T6,
    S_HALT
  } state_e;

  function automatic iclass_e op_class(input logic [4:0] op);
    iclass_e c;
    if (op <= OP_ROL)                      c = CL_RRR;
    else if (op == OP_MUL || op == OP_DIV) c = CL_MD;
    else if (op == OP_NEG || op == OP_NOT) c = CL_UN;
    else if (op == OP_HALT)                c = CL_HALT;
    else                                   c = CL_NOP;
    return c;
  endfunction

endpackage

// File: rtl/reg_sel_decoder.sv
// reg_sel_decoder: 4-to-16 one-hot register select with enable.
//   en_i     : enable; output is all-zero when low
//   sel_i    : register index R0..R15
//   onehot_o : one-hot select, bit n = Rn
module reg_sel_decoder (
  input  logic        en_i,
  input  logic [3:0]  sel_i,
  output logic [15:0] onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[sel_i] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the 32-bit bus datapath.
// Sequences fetch (T0-T2, with memory-wait) and execution of RRR ALU,
// multiply/divide, unary and halt instructions; other opcodes are nops.
//   clk, reset       : clock, async active-high reset
//   run              : start next instruction when high in T0
//   mem_ready        : memory read data valid (sampled in T1/WAIT)
//   ir               : instruction register value
//   *out/*in/IncPc/read, control : datapath strobes and ALU select
//   reg_out, reg_in  : one-hot R0..R15 bus drive / load
//   halted, mem_err  : in S_HALT / sticky memory-wait timeout
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned MEM_WAIT_MAX = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        mem_ready,
  input  logic [31:0] ir,
  output logic        PCout,
  output logic        PCin,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        IncPc,
  output logic        read,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HIin,
  output logic        LOin,
  output logic [15:0] reg_out,
  output logic [15:0] reg_in,
  output logic [3:0]  control,
  output logic        halted,
  output logic        mem_err
);

  localparam int unsigned CW = (MEM_WAIT_MAX < 2) ? 1 : $clog2(MEM_WAIT_MAX + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  logic          mem_err_q, mem_err_d;

  logic [4:0] op;
  logic [3:0] ra, rb, rc;
  iclass_e    cls;
  logic       ro_en, ri_en;
  logic [3:0] ro_sel, ri_sel;
  logic       unused_ir_bits;

  assign op  = ir[OP_MSB:OP_LSB];
  assign ra  = ir[RA_MSB:RA_LSB];
  assign rb  = ir[RB_MSB:RB_LSB];
  assign rc  = ir[RC_MSB:RC_LSB];
  assign cls = op_class(op);
  assign unused_ir_bits = ^ir[RC_LSB-1:0];

  assign cnt_inc = cnt_q + CW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      mem_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mem_err_q <= mem_err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mem_err_d = mem_err_q;
    PCout = 1'b0; PCin = 1'b0; MARin = 1'b0; MDRin = 1'b0; MDRout = 1'b0;
    IRin = 1'b0; Yin = 1'b0; Zin = 1'b0; IncPc = 1'b0; read = 1'b0;
    Zlowout = 1'b0; Zhighout = 1'b0; HIin = 1'b0; LOin = 1'b0;
    control = '0;
    ro_en = 1'b0; ro_sel = '0;
    ri_en = 1'b0; ri_sel = '0;

    unique case (state_q)
      S_RESET: state_d = S_T0;
      S_T0: begin
        // Fetch strobes are qualified by run so an idle T0 never bumps the PC.
        if (run) begin
          PCout = 1'b1; MARin = 1'b1; IncPc = 1'b1; Zin = 1'b1;
          cnt_d   = '0;
          state_d = S_T1;
        end
      end
      S_T1: begin
        Zlowout = 1'b1; PCin = 1'b1; read = 1'b1; MDRin = 1'b1;
        state_d = mem_ready ? S_T2 : S_WAIT;
      end
      S_WAIT: begin
        read = 1'b1; MDRin = 1'b1;
        if (mem_ready) begin
          state_d = S_T2;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc >= CW'(MEM_WAIT_MAX)) begin
            mem_err_d = 1'b1;
            state_d   = S_HALT;
          end
        end
      end
      S_T2: begin
        MDRout = 1'b1; IRin = 1'b1;
        state_d = S_T3;
      end
      S_T3: begin
        unique case (cls)
          CL_RRR:  begin ro_en = 1'b1; ro_sel = rb; Yin = 1'b1; state_d = S_T4; end
          CL_MD:   begin ro_en = 1'b1; ro_sel = ra; Yin = 1'b1; state_d = S_T4; end
          CL_UN: begin
            ro_en = 1'b1; ro_sel = rb; Zin = 1'b1; control = op[3:0];
            state_d = S_T4;
          end
          CL_HALT: state_d = S_HALT;
          default: state_d = S_T0;
        endcase
      end
      S_T4: begin
        unique case (cls)
          CL_RRR: begin
            ro_en = 1'b1; ro_sel = rc; Zin = 1'b1; control = op[3:0];
            state_d = S_T5;
          end
          CL_MD: begin
            ro_en = 1'b1; ro_sel = rb; Zin = 1'b1; control = op[3:0];
            state_d = S_T5;
          end
          CL_UN: begin
            Zlowout = 1'b1; ri_en = 1'b1; ri_sel = ra;
            state_d = S_T0;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T5: begin
        unique case (cls)
          CL_RRR: begin
            Zlowout = 1'b1; ri_en = 1'b1; ri_sel = ra;
            state_d = S_T0;
          end
          CL_MD: begin
            Zlowout = 1'b1; LOin = 1'b1;
            state_d = S_T6;
          end
          default: state_d = S_T0;
        endcase
      end
      S_T6: begin
        Zhighout = 1'b1; HIin = 1'b1;
        state_d = S_T0;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_RESET;
    endcase
  end

  assign halted  = (state_q == S_HALT);
  assign mem_err = mem_err_q;

  reg_sel_decoder u_out_dec (
    .en_i     (ro_en),
    .sel_i    (ro_sel),
    .onehot_o (reg_out)
  );

  reg_sel_decoder u_in_dec (
    .en_i     (ri_en),
    .sel_i    (ri_sel),
    .onehot_o (reg_in)
  );

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        reset, run, mem_ready;
  logic [31:0] ir;
  logic        PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, IncPc, read;
  logic        Zlowout, Zhighout, HIin, LOin;
  logic [15:0] reg_out, reg_in;
  logic [3:0]  control;
  logic        halted, mem_err;

  always #5 clk = ~clk;

  control_sequencer #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .PCin(PCin), .MARin(MARin), .MDRin(MDRin), .MDRout(MDRout),
    .IRin(IRin), .Yin(Yin), .Zin(Zin), .IncPc(IncPc), .read(read),
    .Zlowout(Zlowout), .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .reg_out(reg_out), .reg_in(reg_in), .control(control),
    .halted(halted), .mem_err(mem_err)
  );

  // Strobe bit positions within the 14-bit strobe field
  localparam logic [13:0] B_PCOUT = 14'h2000, B_PCIN  = 14'h1000, B_MARIN = 14'h0800;
  localparam logic [13:0] B_MDRIN = 14'h0400, B_MDROUT = 14'h0200, B_IRIN = 14'h0100;
  localparam logic [13:0] B_YIN   = 14'h0080, B_ZIN   = 14'h0040, B_INCPC = 14'h0020;
  localparam logic [13:0] B_READ  = 14'h0010, B_ZLO   = 14'h0008, B_ZHI   = 14'h0004;
  localparam logic [13:0] B_HIIN  = 14'h0002, B_LOIN  = 14'h0001;

  typedef struct {
    logic        rst;
    logic        run;
    logic        mr;
    logic [31:0] ir;
    logic [51:0] exp;
    string       nm;
  } vec_t;

  vec_t        tbl[$];
  logic [51:0] sb[$];
  int          n_checks = 0;
  int          n_errors = 0;

  function automatic logic [51:0] e(input logic [13:0] s, input logic [15:0] ro,
                                    input logic [15:0] ri, input logic [3:0] c,
                                    input logic h, input logic m);
    return {s, ro, ri, c, h, m};
  endfunction

  function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] a,
                                      input logic [3:0] b, input logic [3:0] c);
    return {op, a, b, c, 15'd0};
  endfunction

  function automatic logic [51:0] act();
    return {PCout, PCin, MARin, MDRin, MDRout, IRin, Yin, Zin, IncPc, read,
            Zlowout, Zhighout, HIin, LOin, reg_out, reg_in, control, halted, mem_err};
  endfunction

  task automatic check(input string nm, input logic [51:0] got, input logic [51:0] ex);
    n_checks++;
    if (got !== ex) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, got, ex);
    end
  endtask

  task automatic sb_compare(input string nm);
    logic [51:0] ex;
    ex = sb.pop_front();
    check(nm, act(), ex);
  endtask

  task automatic step(input logic r, input logic rn, input logic mr,
                      input logic [31:0] i, input logic [51:0] ex, input string nm);
    @(negedge clk);
    reset = r; run = rn; mem_ready = mr; ir = i;
    sb.push_back(ex);
    #1;
    sb_compare(nm);
  endtask

  task automatic tv(input logic r, input logic rn, input logic mr,
                    input logic [31:0] i, input logic [51:0] ex, input string nm);
    vec_t v;
    v.rst = r; v.run = rn; v.mr = mr; v.ir = i; v.exp = ex; v.nm = nm;
    tbl.push_back(v);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [51:0] IDLE, T0F, T1F, WT, T2F, HALTV, ERRV;
    logic [31:0] I_ADD, I_ROR, I_NEG, I_MUL, I_NOP, I_HLT;
    int waits;
    bit done;

    IDLE  = e('0, '0, '0, '0, 1'b0, 1'b0);
    T0F   = e(B_PCOUT | B_MARIN | B_INCPC | B_ZIN, '0, '0, '0, 1'b0, 1'b0);
    T1F   = e(B_ZLO | B_PCIN | B_READ | B_MDRIN, '0, '0, '0, 1'b0, 1'b0);
    WT    = e(B_READ | B_MDRIN, '0, '0, '0, 1'b0, 1'b0);
    T2F   = e(B_MDROUT | B_IRIN, '0, '0, '0, 1'b0, 1'b0);
    HALTV = e('0, '0, '0, '0, 1'b1, 1'b0);
    ERRV  = e('0, '0, '0, '0, 1'b1, 1'b1);

    I_ADD = enc(5'b00000, 4'd5, 4'd2, 4'd4);
    I_ROR = enc(5'b00110, 4'd9, 4'd9, 4'd15);
    I_NEG = enc(5'b01010, 4'd1, 4'd6, 4'd0);
    I_MUL = enc(5'b01000, 4'd3, 4'd7, 4'd0);
    I_NOP = enc(5'b11111, 4'd2, 4'd3, 4'd4);
    I_HLT = enc(5'b11011, 4'd0, 4'd0, 4'd0);

    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; ir = '0;

    tv(1, 0, 0, I_ADD, IDLE, "reset_state");
    tv(0, 0, 0, I_ADD, IDLE, "reset_release");
    // add R5,R2,R4
    tv(0, 1, 1, I_ADD, T0F, "add_t0");
    tv(0, 1, 1, I_ADD, T1F, "add_t1");
    tv(0, 1, 1, I_ADD, T2F, "add_t2");
    tv(0, 1, 1, I_ADD, e(B_YIN, 16'h0004, '0, 4'd0, 0, 0), "add_t3");
    tv(0, 1, 1, I_ADD, e(B_ZIN, 16'h0010, '0, 4'd0, 0, 0), "add_t4");
    tv(0, 1, 1, I_ADD, e(B_ZLO, '0, 16'h0020, 4'd0, 0, 0), "add_t5");
    // ror R9,R9,R15 (destination equals source)
    tv(0, 1, 1, I_ROR, T0F, "ror_t0");
    tv(0, 1, 1, I_ROR, T1F, "ror_t1");
    tv(0, 1, 1, I_ROR, T2F, "ror_t2");
    tv(0, 1, 1, I_ROR, e(B_YIN, 16'h0200, '0, 4'd0, 0, 0), "ror_t3");
    tv(0, 1, 1, I_ROR, e(B_ZIN, 16'h8000, '0, 4'd6, 0, 0), "ror_t4");
    tv(0, 1, 1, I_ROR, e(B_ZLO, '0, 16'h0200, 4'd0, 0, 0), "ror_t5");
    // neg R1,R6 with three memory-wait cycles
    tv(0, 1, 0, I_NEG, T0F, "neg_t0");
    tv(0, 1, 0, I_NEG, T1F, "neg_t1");
    tv(0, 1, 0, I_NEG, WT, "neg_w1");
    tv(0, 1, 0, I_NEG, WT, "neg_w2");
    tv(0, 1, 1, I_NEG, WT, "neg_w3");
    tv(0, 1, 1, I_NEG, T2F, "neg_t2");
    tv(0, 1, 1, I_NEG, e(B_ZIN, 16'h0040, '0, 4'd10, 0, 0), "neg_t3");
    tv(0, 1, 1, I_NEG, e(B_ZLO, '0, 16'h0002, 4'd0, 0, 0), "neg_t4");
    // mul R3,R7
    tv(0, 1, 1, I_MUL, T0F, "mul_t0");
    tv(0, 1, 1, I_MUL, T1F, "mul_t1");
    tv(0, 1, 1, I_MUL, T2F, "mul_t2");
    tv(0, 1, 1, I_MUL, e(B_YIN, 16'h0008, '0, 4'd0, 0, 0), "mul_t3");
    tv(0, 1, 1, I_MUL, e(B_ZIN, 16'h0080, '0, 4'd8, 0, 0), "mul_t4");
    tv(0, 1, 1, I_MUL, e(B_ZLO | B_LOIN, '0, '0, 4'd0, 0, 0), "mul_t5");
    tv(0, 1, 1, I_MUL, e(B_ZHI | B_HIIN, '0, '0, 4'd0, 0, 0), "mul_t6");
    // idle in T0, then undefined opcode with run dropped mid-instruction
    for (int unsigned k = 0; k < 10; k++) tv(0, 0, 1, I_NOP, IDLE, "idle_t0");
    tv(0, 1, 1, I_NOP, T0F, "nop_t0");
    tv(0, 0, 1, I_NOP, T1F, "nop_t1");
    tv(0, 0, 1, I_NOP, T2F, "nop_t2");
    tv(0, 0, 1, I_NOP, IDLE, "nop_t3");
    // halt
    tv(0, 1, 1, I_HLT, T0F, "halt_t0");
    tv(0, 1, 1, I_HLT, T1F, "halt_t1");
    tv(0, 1, 1, I_HLT, T2F, "halt_t2");
    tv(0, 1, 1, I_HLT, IDLE, "halt_t3");
    for (int unsigned k = 0; k < 4; k++) tv(0, k[0], 1, I_HLT, HALTV, "halt_hold");
    tv(1, 1, 1, I_ADD, IDLE, "halt_reset");
    tv(0, 1, 1, I_ADD, IDLE, "halt_reset_release");

    for (int unsigned i = 0; i < tbl.size(); i++)
      step(tbl[i].rst, tbl[i].run, tbl[i].mr, tbl[i].ir, tbl[i].exp, tbl[i].nm);

    // Asynchronous reset in the middle of an add's T4
    step(0, 1, 1, I_ADD, T0F, "add2_t0");
    step(0, 1, 1, I_ADD, T1F, "add2_t1");
    step(0, 1, 1, I_ADD, T2F, "add2_t2");
    step(0, 1, 1, I_ADD, e(B_YIN, 16'h0004, '0, 4'd0, 0, 0), "add2_t3");
    step(0, 1, 1, I_ADD, e(B_ZIN, 16'h0010, '0, 4'd0, 0, 0), "add2_t4");
    #2 reset = 1'b1;
    sb.push_back(IDLE);
    #1 sb_compare("rst_async");
    @(posedge clk);
    sb.push_back(IDLE);
    #1 sb_compare("rst_no_writeback");
    step(0, 1, 1, I_ADD, IDLE, "rst2_release");

    // Memory never ready: timeout into halt with mem_err
    step(0, 1, 0, I_ADD, T0F, "to_t0");
    step(0, 1, 0, I_ADD, T1F, "to_t1");
    waits = 0;
    done  = 1'b0;
    for (int k = 0; k < 40 && !done; k++) begin
      @(negedge clk);
      mem_ready = 1'b0;
      #1;
      if (halted === 1'b1) begin
        done = 1'b1;
      end else begin
        waits++;
        sb.push_back(WT);
        sb_compare("to_wait");
      end
    end
    check("to_reached_halt", 52'(done), 52'd1);
    check("to_wait_cycles", 52'(waits), 52'd15);
    sb.push_back(ERRV);
    sb_compare("to_halt_err");
    step(0, 0, 1, I_ADD, ERRV, "to_sticky_a");
    step(0, 1, 1, I_ADD, ERRV, "to_sticky_b");
    step(1, 1, 1, I_ADD, IDLE, "to_reset_clears");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
